// File: rtl/bit_serial_sequencer.sv
// bit_serial_sequencer
//   Bit-serial PE controller. Latches one 32-bit instruction on start and
//   walks dual-port BRAM addresses, write enables, ALU op and neighbour-move
//   controls one bit (ALU ops) or one bit pair (moves) at a time.
//
//   Ports:
//     clk, reset (async, active-low)
//     start, instruction[31:0]  : issue request ([31:26] op, [25:21] rd,
//                                 [20:16] rs1, [15:11] rs2)
//     busy, done, illegal       : handshake / status
//     alu_op[3:0]               : 0 ADD, 1 SUB, 9/10 MSB-first, F move pass
//     wea, web, addra, addrb    : BRAM port controls
//     dir_en[3:0], dir_mode[7:0]: {N,S,W,E} move controls
//     count[CNT_W-1:0]          : bit/pass index (debug)
//
//   Optional feature macro: BITSEQ_ILLEGAL_TRAP_EN
//     defined   : bad opcode or register index >= NREG -> done with illegal=1
//     undefined : bad opcode completes as a no-op, illegal tied to 0
//
//   All outputs are registered from the current FSM state, so they trail the
//   state register by one cycle.

module bit_serial_sequencer #(
    parameter int unsigned LENGTH = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 0,
    parameter int unsigned CNT_W  = $clog2(LENGTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       instruction,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [3:0]        alu_op,
    output logic              wea,
    output logic              web,
    output logic [ADDR_W-1:0] addra,
    output logic [ADDR_W-1:0] addrb,
    output logic [3:0]        dir_en,
    output logic [7:0]        dir_mode,
    output logic [CNT_W-1:0]  count
);

    if (64'(NREG) * 64'(LENGTH) > (64'd1 << ADDR_W)) begin : g_addr_chk
        $error("bit_serial_sequencer: NREG*LENGTH exceeds BRAM address space");
    end
    if ((LENGTH % 2) != 0 || LENGTH < 2) begin : g_len_chk
        $error("bit_serial_sequencer: LENGTH must be even and >= 2");
    end

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       r_state;
    logic [20:0]      r_instr;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_wait;
    logic             r_ill;
    logic             r_illegal;

    logic w_unused;
    assign w_unused = ^instruction[10:0];

    // Decode of the latched instruction
    logic [5:0] w_op;
    logic [4:0] w_rd, w_rs1, w_rs2;
    logic       w_alu, w_desc, w_move, w_latch;
    logic [3:0] w_dir;
    logic [3:0] w_alu_code;
    assign w_op   = r_instr[20:15];
    assign w_rd   = r_instr[14:10];
    assign w_rs1  = r_instr[9:5];
    assign w_rs2  = r_instr[4:0];
    assign w_desc  = (w_op == 6'd9) || (w_op == 6'd10);
    assign w_alu   = (w_op == 6'd0) || (w_op == 6'd1) || w_desc;
    assign w_move  = (w_op >= 6'd5) && (w_op <= 6'd8);
    assign w_latch = (w_op == 6'd5) || (w_op == 6'd8);
    assign w_dir   = (w_op == 6'd5) ? 4'b0001 :
                     (w_op == 6'd6) ? 4'b0010 :
                     (w_op == 6'd7) ? 4'b0100 :
                     (w_op == 6'd8) ? 4'b1000 : 4'b0000;
    assign w_alu_code = w_alu ? w_op[3:0] : (w_move ? 4'hF : 4'h0);

    // Decode of the incoming instruction for acceptance
    logic [5:0] w_in_op;
    logic       w_in_alu, w_in_move, w_in_ok;
    assign w_in_op   = instruction[31:26];
    assign w_in_alu  = (w_in_op <= 6'd1) || (w_in_op == 6'd9) || (w_in_op == 6'd10);
    assign w_in_move = (w_in_op >= 6'd5) && (w_in_op <= 6'd8);
`ifdef BITSEQ_ILLEGAL_TRAP_EN
    assign w_in_ok = (w_in_alu && 32'(instruction[25:21]) < NREG
                               && 32'(instruction[20:16]) < NREG
                               && 32'(instruction[15:11]) < NREG)
                  || (w_in_move && 32'(instruction[25:21]) < NREG
                                && 32'(instruction[20:16]) < NREG);
`else
    assign w_in_ok = w_in_alu || w_in_move;
`endif

    function automatic logic [ADDR_W-1:0] f_base(input logic [4:0] r, input logic desc);
        logic [31:0] t;
        t = 32'(r) * LENGTH + (desc ? LENGTH - 1 : 32'd0);
        return t[ADDR_W-1:0];
    endfunction

    // Moves step two rows per pass; ALU ops step one row per bit
    logic [31:0]       w_idx;
    logic [ADDR_W-1:0] w_off, w_src_a, w_src_b, w_dst;
    logic [ADDR_W-1:0] w_rd_a, w_rd_b, w_wb_a, w_wb_b;
    logic              w_last;
    assign w_idx   = w_move ? (32'(r_cnt) << 1) : 32'(r_cnt);
    assign w_off   = w_idx[ADDR_W-1:0];
    assign w_src_a = f_base(w_rs1, w_desc);
    assign w_src_b = f_base(w_rs2, w_desc);
    assign w_dst   = f_base(w_rd, w_desc);
    assign w_rd_a  = w_desc ? w_src_a - w_off : w_src_a + w_off;
    assign w_rd_b  = w_move ? w_src_a + w_off + 1'b1
                            : (w_desc ? w_src_b - w_off : w_src_b + w_off);
    assign w_wb_a  = w_desc ? w_dst - w_off : w_dst + w_off;
    assign w_wb_b  = w_dst + w_off + 1'b1;
    assign w_last  = 32'(r_cnt) == (w_move ? LENGTH / 2 - 1 : LENGTH - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_cnt   <= '0;
            r_wait  <= '0;
            r_ill   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_instr <= instruction[31:11];
                    r_cnt   <= '0;
                    r_wait  <= '0;
`ifdef BITSEQ_ILLEGAL_TRAP_EN
                    r_ill   <= !w_in_ok;
`endif
                    r_state <= w_in_ok ? S_RD : S_DONE;
                end
                S_RD: begin
                    r_wait  <= '0;
                    r_state <= (RD_LAT == 0) ? S_WB : S_WAIT;
                end
                S_WAIT: begin
                    r_wait <= r_wait + 2'd1;
                    if (32'(r_wait) + 32'd1 >= RD_LAT) r_state <= S_WB;
                end
                S_WB: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (!w_last)      r_state <= S_RD;
                    else if (w_latch) r_state <= S_LATCH;
                    else              r_state <= S_DONE;
                end
                S_LATCH: r_state <= S_DONE;
                S_DONE: begin
                    r_ill   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic              w_pass_st, w_busy_st;
    logic              w_nx_wea, w_nx_web;
    logic [ADDR_W-1:0] w_nx_a, w_nx_b;
    logic [3:0]        w_nx_den;
    logic [7:0]        w_nx_mode;
    assign w_pass_st = (r_state == S_RD) || (r_state == S_WAIT) || (r_state == S_WB);
    assign w_busy_st = w_pass_st || (r_state == S_LATCH);

    always_comb begin
        w_nx_wea  = 1'b0;
        w_nx_web  = 1'b0;
        w_nx_a    = '0;
        w_nx_b    = '0;
        w_nx_den  = '0;
        w_nx_mode = '0;
        if (r_state == S_RD || r_state == S_WAIT) begin
            w_nx_a = w_rd_a;
            w_nx_b = w_rd_b;
        end else if (r_state == S_WB) begin
            w_nx_a   = w_wb_a;
            w_nx_b   = w_move ? w_wb_b : '0;
            w_nx_wea = 1'b1;
            w_nx_web = w_move;
        end
        if (w_move && w_busy_st) begin
            w_nx_den = w_dir;
            for (int unsigned j = 0; j < 4; j++) begin
                if (w_dir[j]) w_nx_mode[2*j +: 2] = (r_state == S_LATCH) ? 2'd2 : 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            r_illegal <= 1'b0;
            alu_op    <= '0;
            wea       <= 1'b0;
            web       <= 1'b0;
            addra     <= '0;
            addrb     <= '0;
            dir_en    <= '0;
            dir_mode  <= '0;
            count     <= '0;
        end else begin
            busy      <= w_busy_st;
            done      <= (r_state == S_DONE);
            r_illegal <= (r_state == S_DONE) && r_ill;
            alu_op    <= (r_state != S_IDLE) ? w_alu_code : 4'h0;
            wea       <= w_nx_wea;
            web       <= w_nx_web;
            addra     <= w_nx_a;
            addrb     <= w_nx_b;
            dir_en    <= w_nx_den;
            dir_mode  <= w_nx_mode;
            count     <= r_cnt;
        end
    end

`ifdef BITSEQ_ILLEGAL_TRAP_EN
    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_sequencer.sv
// Directed bench for bit_serial_sequencer: one instance with RD_LAT=0 for
// ALU-op, handshake, reset-abort and illegal-op cases, one with RD_LAT=1
// for the east move.

module tb_bit_serial_sequencer;

    localparam int unsigned AW = 10;
    localparam int unsigned CW = 6;
`ifdef BITSEQ_ILLEGAL_TRAP_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [31:0] instruction = '0;

    logic          busy0, done0, ill0, wea0, web0;
    logic [3:0]    alu0, den0;
    logic [AW-1:0] addra0, addrb0;
    logic [7:0]    dmode0;
    logic [CW-1:0] cnt0;

    logic          busy1, done1, ill1, wea1, web1;
    logic [3:0]    alu1, den1;
    logic [AW-1:0] addra1, addrb1;
    logic [7:0]    dmode1;
    logic [CW-1:0] cnt1;

    bit_serial_sequencer #(.LENGTH(32), .NREG(32), .ADDR_W(AW), .RD_LAT(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .instruction(instruction),
        .busy(busy0), .done(done0), .illegal(ill0), .alu_op(alu0),
        .wea(wea0), .web(web0), .addra(addra0), .addrb(addrb0),
        .dir_en(den0), .dir_mode(dmode0), .count(cnt0)
    );

    bit_serial_sequencer #(.LENGTH(32), .NREG(32), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .instruction(instruction),
        .busy(busy1), .done(done1), .illegal(ill1), .alu_op(alu1),
        .wea(wea1), .web(web1), .addra(addra1), .addrb(addrb1),
        .dir_en(den1), .dir_mode(dmode1), .count(cnt1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
        return {op[5:0], rd[4:0], rs1[4:0], rs2[4:0], 11'd0};
    endfunction

    // Caller has instruction set and start0=1; first tick is the accept edge.
    // A stray start is raised mid-run; with chain set, the next instruction is
    // presented during the done cycle.
    task automatic run_alu(input string tag, input logic [AW-1:0] ra0, input logic [AW-1:0] rb0,
                           input logic [AW-1:0] wb0, input logic [AW-1:0] wblast,
                           input logic [3:0] op, input bit chain, input logic [31:0] nxt);
        int n_done = 0;
        int n_busy = 0;
        int bad_we = 0;
        tick;
        start0 = 1'b0;
        check({tag, "_done_low_at_accept"}, done0, 0);
        for (int n = 1; n <= 80; n++) begin
            tick;
            if (n == 1) begin
                check({tag, "_rd0_addra"}, addra0, ra0);
                check({tag, "_rd0_addrb"}, addrb0, rb0);
                check({tag, "_rd0_wea"}, wea0, 0);
                check({tag, "_busy"}, busy0, 1);
                check({tag, "_alu_op"}, alu0, op);
                check({tag, "_count0"}, cnt0, 0);
            end
            if (n == 2) begin
                check({tag, "_wb0_addra"}, addra0, wb0);
                check({tag, "_wb0_wea"}, wea0, 1);
            end
            if (n == 20) begin
                start0 = 1'b1;
                instruction = mk(1, 9, 9, 9);
            end
            if (n == 21) start0 = 1'b0;
            if (n == 64) begin
                check({tag, "_wblast_addra"}, addra0, wblast);
                check({tag, "_wblast_wea"}, wea0, 1);
                check({tag, "_alu_op_held"}, alu0, op);
            end
            if (wea0 && (n % 2 == 1)) bad_we++;
            if (busy0) n_busy++;
            if (done0) begin
                n_done = n;
                check({tag, "_busy_low_in_done"}, busy0, 0);
                if (chain) begin
                    instruction = nxt;
                    start0 = 1'b1;
                end
                break;
            end
        end
        check({tag, "_done_latency"}, n_done, 65);
        check({tag, "_busy_cycles"}, n_busy, 64);
        check({tag, "_stray_writes"}, bad_we, 0);
    endtask

    initial begin
        int seen;
        int n_done;
        int n_wb;
        int n_latch;
        int bad;

        #1 reset = 1'b0;
        #2;
        check("rst_busy0", busy0, 0);
        check("rst_done0", done0, 0);
        check("rst_addra0", addra0, 0);
        check("rst_wea0", wea0, 0);
        check("rst_alu0", alu0, 0);
        check("rst_dmode1", dmode1, 0);
        check("rst_addrb1", addrb1, 0);
        @(negedge clk);
        reset = 1'b1;
        tick;

        // ADD r3=r1+r2, then op 9 chained from the done cycle
        instruction = mk(0, 3, 1, 2);
        start0 = 1'b1;
        run_alu("add", 10'd32, 10'd64, 10'd96, 10'd127, 4'd0, 1'b1, mk(9, 0, 1, 2));
        run_alu("msb", 10'd63, 10'd95, 10'd31, 10'd0, 4'd9, 1'b0, 32'd0);
        tick;
        check("msb_done_one_cycle", done0, 0);

        // SUB aborted by reset at bit 10
        instruction = mk(1, 5, 6, 7);
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        for (int n = 1; n <= 21; n++) tick;
        check("abort_count_bit10", cnt0, 10);
        reset = 1'b0;
        #1;
        check("abort_busy", busy0, 0);
        check("abort_addra", addra0, 0);
        check("abort_alu", alu0, 0);
        check("abort_count", cnt0, 0);
        repeat (2) tick;
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            tick;
            if (done0 || busy0) seen++;
        end
        check("abort_no_done", seen, 0);
        instruction = mk(1, 5, 6, 7);
        start0 = 1'b1;
        run_alu("sub", 10'd192, 10'd224, 10'd160, 10'd191, 4'd1, 1'b0, 32'd0);
        tick;

        // East move r4 -> r4 on the RD_LAT=1 instance
        instruction = mk(5, 4, 4, 0);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        n_done = 0; n_wb = 0; n_latch = 0; bad = 0;
        for (int n = 1; n <= 60; n++) begin
            tick;
            if (n == 1) begin
                check("mv_rd0_addra", addra1, 128);
                check("mv_rd0_addrb", addrb1, 129);
                check("mv_dir_en", den1, 4'b0001);
                check("mv_dir_mode_pass", dmode1, 8'h01);
                check("mv_alu_op", alu1, 4'hF);
            end
            if (n == 3) begin
                check("mv_wb0_addra", addra1, 128);
                check("mv_wb0_addrb", addrb1, 129);
                check("mv_wb0_web", web1, 1);
            end
            if (n == 48) begin
                check("mv_wblast_addra", addra1, 158);
                check("mv_wblast_addrb", addrb1, 159);
                check("mv_wblast_we", {wea1, web1}, 2'b11);
            end
            if (n == 49) check("mv_latch_mode", dmode1, 8'h02);
            if (wea1 && web1) n_wb++;
            if ((wea1 || web1) && (n % 3 != 0)) bad++;
            if (dmode1 == 8'h02) n_latch++;
            if (done1) begin
                n_done = n;
                break;
            end
        end
        check("mv_done_latency", n_done, 50);
        check("mv_wb_count", n_wb, 16);
        check("mv_latch_cycles", n_latch, 1);
        check("mv_stray_writes", bad, 0);
        tick;

        // Unsupported opcode 3
        instruction = mk(3, 1, 2, 3);
        start0 = 1'b1;
        tick;
        start0 = 1'b0;
        check("bad_done_at_accept", done0, 0);
        tick;
        check("bad_done", done0, 1);
        check("bad_illegal", ill0, EXP_ILL);
        check("bad_wea", wea0, 0);
        check("bad_busy", busy0, 0);
        tick;
        check("bad_done_pulse", done0, 0);
        check("bad_illegal_clear", ill0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
